// File: rtl/core_pkg.sv
// Core-wide types shared by the machine-mode CSR path.
// Provides Xlen, CSR operation codes and mcause values.
package core_pkg;

    localparam int unsigned Xlen = 32;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpCSRRW = 3'd1,
        OpCSRRS = 3'd2,
        OpCSRRC = 3'd3,
        OpMret  = 3'd4
    } csr_op_e;

    typedef enum logic [3:0] {
        CauseInstrMisaligned = 4'd0,
        CauseInstrFault      = 4'd1,
        CauseIllegalInstr    = 4'd2,
        CauseBreakpoint      = 4'd3,
        CauseEcallM          = 4'd11
    } csr_mcause_e;

endpackage

// File: rtl/csr_pkg.sv
// CSR issue sequencer state encoding.
// Shared by csr_issue and anything that observes its state.
package csr_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StIssue = 2'd2,
        StResp  = 2'd3
    } csr_issue_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Only built when CSR_ISSUE_STALL_CNT_EN is defined.
`ifdef CSR_ISSUE_STALL_CNT_EN
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count up on inc_i, stick at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/csr_issue.sv
// Serializing initiator for machine-mode CSR, MRET and trap requests.
// Optional drain-stall counter: define CSR_ISSUE_STALL_CNT_EN.
module csr_issue
    import core_pkg::*;
    import csr_pkg::*;
#(
    parameter int unsigned StallCntW    = 32,
    parameter int unsigned NextPcOffset = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  csr_op_e              req_op_i,
    input  logic [11:0]          req_addr_i,
    input  logic [Xlen-1:0]      req_rs1_i,
    input  logic [4:0]           req_rd_i,
    input  logic [Xlen-1:0]      req_pc_i,
    input  logic                 req_expt_valid_i,
    input  csr_mcause_e          req_expt_cause_i,
    input  logic [Xlen-1:0]      req_expt_value_i,
    input  logic                 pipe_empty_i,
    input  logic                 kill_i,
    output logic                 csr_valid_o,
    output csr_op_e              csr_op_o,
    output logic [11:0]          csr_addr_o,
    output logic [Xlen-1:0]      csr_rs1_o,
    output logic [Xlen-1:0]      csr_pc_o,
    output logic                 csr_expt_valid_o,
    output csr_mcause_e          csr_expt_cause_o,
    output logic [Xlen-1:0]      csr_expt_value_o,
    input  logic [Xlen-1:0]      csr_rdata_i,
    input  logic                 csr_trap_i,
    input  logic [Xlen-1:0]      csr_trap_vector_i,
    output logic                 wb_valid_o,
    output logic [4:0]           wb_rd_o,
    output logic [Xlen-1:0]      wb_data_o,
    output logic                 redirect_valid_o,
    output logic [Xlen-1:0]      redirect_pc_o,
    output logic [StallCntW-1:0] stall_cnt_o
);

    csr_issue_state_e state_q, state_d;

    csr_op_e          op_q;
    logic [11:0]      addr_q;
    logic [Xlen-1:0]  rs1_q;
    logic [4:0]       rd_q;
    logic [Xlen-1:0]  pc_q;
    logic             ev_q;
    csr_mcause_e      ec_q;
    logic [Xlen-1:0]  eval_q;

    logic             wb_valid_q;
    logic [4:0]       wb_rd_q;
    logic [Xlen-1:0]  wb_data_q;
    logic             redir_valid_q;
    logic [Xlen-1:0]  redir_pc_q;

    logic             is_rw;
    logic             wb_en;
    logic [Xlen-1:0]  next_pc;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: kill beats pipe_empty in DRAIN, ISSUE is committed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid_i) state_d = StDrain;
            StDrain: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else if (pipe_empty_i) begin
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture the request on accept; held until the next accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q   <= OpNone;
            addr_q <= '0;
            rs1_q  <= '0;
            rd_q   <= '0;
            pc_q   <= '0;
            ev_q   <= 1'b0;
            ec_q   <= CauseInstrMisaligned;
            eval_q <= '0;
        end else if ((state_q == StIdle) && req_valid_i) begin
            op_q   <= req_op_i;
            addr_q <= req_addr_i;
            rs1_q  <= req_rs1_i;
            rd_q   <= req_rd_i;
            pc_q   <= req_pc_i;
            ev_q   <= req_expt_valid_i;
            ec_q   <= req_expt_cause_i;
            eval_q <= req_expt_value_i;
        end
    end

    // Only the Zicsr read-modify-write ops return an old value.
    always_comb begin
        is_rw = 1'b0;
        unique case (op_q)
            OpCSRRW, OpCSRRS, OpCSRRC: is_rw = 1'b1;
            default:                   is_rw = 1'b0;
        endcase
    end

    assign wb_en   = !csr_trap_i && is_rw && (rd_q != 5'd0);
    assign next_pc = pc_q + Xlen'(NextPcOffset);

    // Latch the CSR file response in ISSUE; it lives for RESP only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else if (state_q == StIssue) begin
            wb_valid_q    <= wb_en;
            wb_rd_q       <= rd_q;
            wb_data_q     <= csr_rdata_i;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= csr_trap_i ? csr_trap_vector_i : next_pc;
        end else begin
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end
    end

    assign req_ready_o      = (state_q == StIdle) && !rst_i;
    assign csr_valid_o      = (state_q == StIssue);
    assign csr_op_o         = op_q;
    assign csr_addr_o       = addr_q;
    assign csr_rs1_o        = rs1_q;
    assign csr_pc_o         = pc_q;
    assign csr_expt_valid_o = ev_q;
    assign csr_expt_cause_o = ec_q;
    assign csr_expt_value_o = eval_q;

    assign wb_valid_o       = wb_valid_q;
    assign wb_rd_o          = wb_rd_q;
    assign wb_data_o        = wb_data_q;
    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;

`ifdef CSR_ISSUE_STALL_CNT_EN
    logic stall_inc;

    assign stall_inc = (state_q == StDrain) && !pipe_empty_i && !kill_i;

    sat_counter #(
        .Width (StallCntW)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_csr_issue.sv
// Scoreboard bench for csr_issue.
// Expected responses are queued at drive time, popped on redirect.
module tb_csr_issue;
    import core_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    csr_op_e           req_op_i = OpNone;
    logic [11:0]       req_addr_i = '0;
    logic [Xlen-1:0]   req_rs1_i = '0;
    logic [4:0]        req_rd_i = '0;
    logic [Xlen-1:0]   req_pc_i = '0;
    logic              req_expt_valid_i = 1'b0;
    csr_mcause_e       req_expt_cause_i = CauseInstrMisaligned;
    logic [Xlen-1:0]   req_expt_value_i = '0;
    logic              pipe_empty_i = 1'b1;
    logic              kill_i = 1'b0;
    logic              csr_valid_o;
    csr_op_e           csr_op_o;
    logic [11:0]       csr_addr_o;
    logic [Xlen-1:0]   csr_rs1_o;
    logic [Xlen-1:0]   csr_pc_o;
    logic              csr_expt_valid_o;
    csr_mcause_e       csr_expt_cause_o;
    logic [Xlen-1:0]   csr_expt_value_o;
    logic [Xlen-1:0]   csr_rdata_i = '0;
    logic              csr_trap_i = 1'b0;
    logic [Xlen-1:0]   csr_trap_vector_i = '0;
    logic              wb_valid_o;
    logic [4:0]        wb_rd_o;
    logic [Xlen-1:0]   wb_data_o;
    logic              redirect_valid_o;
    logic [Xlen-1:0]   redirect_pc_o;
    logic [31:0]       stall_cnt_o;

    csr_issue #(
        .StallCntW    (32),
        .NextPcOffset (4)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_op_i          (req_op_i),
        .req_addr_i        (req_addr_i),
        .req_rs1_i         (req_rs1_i),
        .req_rd_i          (req_rd_i),
        .req_pc_i          (req_pc_i),
        .req_expt_valid_i  (req_expt_valid_i),
        .req_expt_cause_i  (req_expt_cause_i),
        .req_expt_value_i  (req_expt_value_i),
        .pipe_empty_i      (pipe_empty_i),
        .kill_i            (kill_i),
        .csr_valid_o       (csr_valid_o),
        .csr_op_o          (csr_op_o),
        .csr_addr_o        (csr_addr_o),
        .csr_rs1_o         (csr_rs1_o),
        .csr_pc_o          (csr_pc_o),
        .csr_expt_valid_o  (csr_expt_valid_o),
        .csr_expt_cause_o  (csr_expt_cause_o),
        .csr_expt_value_o  (csr_expt_value_o),
        .csr_rdata_i       (csr_rdata_i),
        .csr_trap_i        (csr_trap_i),
        .csr_trap_vector_i (csr_trap_vector_i),
        .wb_valid_o        (wb_valid_o),
        .wb_rd_o           (wb_rd_o),
        .wb_data_o         (wb_data_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic            wb_valid;
        logic [4:0]      rd;
        logic [Xlen-1:0] data;
        logic [Xlen-1:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_stall = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int stall_ref();
`ifdef CSR_ISSUE_STALL_CNT_EN
        return exp_stall;
`else
        return 0;
`endif
    endfunction

    // Response monitor: each redirect consumes one scoreboard entry.
    always @(negedge clk_i) begin
        if (!rst_i && redirect_valid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_redirect", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_valid", wb_valid_o, mon_e.wb_valid);
                if (mon_e.wb_valid) begin
                    check("wb_rd", wb_rd_o, mon_e.rd);
                    check("wb_data", wb_data_o, mon_e.data);
                end
                check("redirect_pc", redirect_pc_o, mon_e.pc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready_o, 0);
        check({tag, "_csr_valid"}, csr_valid_o, 0);
        check({tag, "_csr_op"}, csr_op_o, 0);
        check({tag, "_csr_addr"}, csr_addr_o, 0);
        check({tag, "_csr_rs1"}, csr_rs1_o, 0);
        check({tag, "_csr_pc"}, csr_pc_o, 0);
        check({tag, "_expt_v"}, csr_expt_valid_o, 0);
        check({tag, "_expt_c"}, csr_expt_cause_o, 0);
        check({tag, "_expt_val"}, csr_expt_value_o, 0);
        check({tag, "_wb_valid"}, wb_valid_o, 0);
        check({tag, "_wb_rd"}, wb_rd_o, 0);
        check({tag, "_wb_data"}, wb_data_o, 0);
        check({tag, "_redir_v"}, redirect_valid_o, 0);
        check({tag, "_redir_pc"}, redirect_pc_o, 0);
        check({tag, "_stall"}, stall_cnt_o, 0);
    endtask

    task automatic do_req(input csr_op_e op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] rd,
                          input logic [31:0] pc, input logic ev,
                          input csr_mcause_e ec, input logic [31:0] evl,
                          input int drain, input logic [31:0] rdata,
                          input logic trap, input logic [31:0] vec,
                          input logic kill_at_issue, input logic rst_in_resp);
        exp_t e;
        int   n;
        check("ready_idle", req_ready_o, 1);
        req_valid_i      = 1'b1;
        req_op_i         = op;
        req_addr_i       = addr;
        req_rs1_i        = rs1;
        req_rd_i         = rd;
        req_pc_i         = pc;
        req_expt_valid_i = ev;
        req_expt_cause_i = ec;
        req_expt_value_i = evl;
        e.wb_valid = !trap && rd != 5'd0 &&
                     (op == OpCSRRW || op == OpCSRRS || op == OpCSRRC);
        e.rd   = rd;
        e.data = rdata;
        e.pc   = trap ? vec : pc + 32'd4;
        sb_q.push_back(e);
        @(negedge clk_i);
        req_valid_i      = 1'b0;
        req_addr_i       = ~addr;
        req_rs1_i        = ~rs1;
        req_pc_i         = ~pc;
        req_expt_value_i = ~evl;
        check("ready_drain", req_ready_o, 0);
        pipe_empty_i = 1'b0;
        for (int i = 0; i < drain; i++) begin
            check("valid_in_drain", csr_valid_o, 0);
            @(negedge clk_i);
            exp_stall++;
        end
        check("stall_drain", stall_cnt_o, stall_ref());
        pipe_empty_i = 1'b1;
        @(negedge clk_i);
        n = 1;
        while (!csr_valid_o && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        check("issue_lat", n, 1);
        check("csr_valid", csr_valid_o, 1);
        check("csr_op", csr_op_o, op);
        check("csr_addr", csr_addr_o, addr);
        check("csr_rs1", csr_rs1_o, rs1);
        check("csr_pc", csr_pc_o, pc);
        check("csr_expt_v", csr_expt_valid_o, ev);
        check("csr_expt_c", csr_expt_cause_o, ec);
        check("csr_expt_val", csr_expt_value_o, evl);
        csr_rdata_i       = rdata;
        csr_trap_i        = trap;
        csr_trap_vector_i = vec;
        kill_i            = kill_at_issue;
        if (rst_in_resp) begin
            @(posedge clk_i);
            #2 rst_i = 1'b1;
            void'(sb_q.pop_back());
            exp_stall = 0;
            #1 check_all_zero("rst_resp");
            kill_i     = 1'b0;
            csr_trap_i = 1'b0;
            @(negedge clk_i);
            rst_i = 1'b0;
            repeat (4) begin
                @(negedge clk_i);
                check("post_rst_valid", csr_valid_o, 0);
                check("post_rst_ready", req_ready_o, 1);
            end
            return;
        end
        @(negedge clk_i);
        kill_i            = 1'b0;
        csr_trap_i        = 1'b0;
        csr_rdata_i       = '0;
        csr_trap_vector_i = '0;
        check("valid_one_cycle", csr_valid_o, 0);
        check("redirect_in_resp", redirect_valid_o, 1);
        @(negedge clk_i);
        check("wb_cleared", wb_valid_o, 0);
        check("redirect_cleared", redirect_valid_o, 0);
        check("ready_after", req_ready_o, 1);
        check("stall_after", stall_cnt_o, stall_ref());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #3 check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        do_req(OpCSRRW, 12'h340, 32'hAA, 5'd5, 32'h200, 1'b0,
               CauseInstrMisaligned, 32'h0, 0, 32'h11, 1'b0, 32'h0,
               1'b0, 1'b0);
        do_req(OpCSRRS, 12'h300, 32'h8, 5'd0, 32'h300, 1'b0,
               CauseInstrMisaligned, 32'h0, 0, 32'h55, 1'b0, 32'h0,
               1'b1, 1'b0);
        do_req(OpNone, 12'h000, 32'h0, 5'd7, 32'h100, 1'b1,
               CauseIllegalInstr, 32'hDEAD, 0, 32'h99, 1'b1, 32'h8000,
               1'b0, 1'b0);
        do_req(OpCSRRC, 12'h344, 32'h3, 5'd3, 32'h400, 1'b0,
               CauseInstrMisaligned, 32'h0, 7, 32'h77, 1'b0, 32'h0,
               1'b0, 1'b0);
        check("stall_seven", stall_cnt_o, stall_ref());
        do_req(OpMret, 12'h302, 32'h0, 5'd0, 32'h500, 1'b0,
               CauseInstrMisaligned, 32'h0, 1, 32'h0, 1'b1, 32'h1234,
               1'b0, 1'b0);
        do_req(OpCSRRW, 12'h341, 32'h5, 5'd1, 32'hFFFF_FFFC, 1'b0,
               CauseInstrMisaligned, 32'h0, 0, 32'hCAFE, 1'b0, 32'h0,
               1'b0, 1'b0);

        check("ready_kill", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_op_i    = OpCSRRW;
        req_addr_i  = 12'h340;
        req_rd_i    = 5'd9;
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        pipe_empty_i = 1'b0;
        @(negedge clk_i);
        exp_stall++;
        kill_i       = 1'b1;
        pipe_empty_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill_ready", req_ready_o, 1);
        check("kill_valid", csr_valid_o, 0);
        check("kill_stall", stall_cnt_o, stall_ref());
        repeat (4) begin
            @(negedge clk_i);
            check("kill_no_valid", csr_valid_o, 0);
            check("kill_no_wb", wb_valid_o, 0);
        end

        req_valid_i = 1'b1;
        req_rd_i    = 5'd4;
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        pipe_empty_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        exp_stall = 0;
        #1 check_all_zero("rst_drain");
        pipe_empty_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            check("post_drain_rst_valid", csr_valid_o, 0);
        end

        do_req(OpCSRRS, 12'h305, 32'h1, 5'd2, 32'h600, 1'b0,
               CauseInstrMisaligned, 32'h0, 2, 32'h42, 1'b0, 32'h0,
               1'b0, 1'b1);
        do_req(OpCSRRW, 12'h340, 32'h12, 5'd6, 32'h700, 1'b0,
               CauseInstrMisaligned, 32'h0, 3, 32'h3C, 1'b0, 32'h0,
               1'b0, 1'b0);

        repeat (3) @(negedge clk_i);
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/csr_issue.md
Name: csr_issue

Overview:
- Initiator side of the machine-mode CSR interface. Accepts one CSR/MRET/exception request from decode, drains older in-flight instructions, and presents the request to the CSR file for exactly one cycle.
- Captures the CSR file's read data and trap decision, then returns a registered writeback and a fetch redirect/flush.
- Serializes all CSR traffic, so the CSR file never sees back-to-back or speculative accesses.

Parameters:
- StallCntW, 32, width of the saturating drain-stall counter (optional feature only).
- NextPcOffset, 4, byte offset added to the request PC for the refetch redirect after a non-trapping completion.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  decode request valid
- req_ready_o  out  1  block can accept a request
- req_op_i  in  csr_op_e  CSR operation (OpCSRRW/RS/RC/OpMret/other)
- req_addr_i  in  12  CSR address
- req_rs1_i  in  Xlen  rs1 operand
- req_rd_i  in  5  destination register
- req_pc_i  in  Xlen  instruction PC
- req_expt_valid_i  in  1  request carries an exception
- req_expt_cause_i  in  csr_mcause_e  exception cause
- req_expt_value_i  in  Xlen  mtval value
- pipe_empty_i  in  1  no older instruction in flight
- kill_i  in  1  discard the pending request (older redirect)
- csr_valid_o  out  1  CSR file access strobe
- csr_op_o, csr_addr_o, csr_rs1_o, csr_pc_o, csr_expt_valid_o, csr_expt_cause_o, csr_expt_value_o  out  as req_*  registered request
- csr_rdata_i  in  Xlen  CSR file read data
- csr_trap_i  in  1  CSR file raise_trap
- csr_trap_vector_i  in  Xlen  CSR file trap target
- wb_valid_o  out  1  writeback strobe
- wb_rd_o  out  5  writeback register
- wb_data_o  out  Xlen  old CSR value
- redirect_valid_o  out  1  fetch redirect and younger-instruction flush
- redirect_pc_o  out  Xlen  redirect target
- stall_cnt_o  out  StallCntW  drain-stall cycles (optional feature)

Behaviour:
- Reset (async, rst_i=1): state IDLE; all request registers and all outputs 0; req_ready_o reads 0 while rst_i is high. Reset mid-operation discards the request with no csr_valid_o, wb, or redirect.
- States: IDLE, DRAIN, ISSUE, RESP.
- IDLE: req_ready_o=1. On req_valid_i, capture all req_* fields and go to DRAIN. No other state asserts ready.
- DRAIN: if kill_i, go to IDLE with no side effects. If pipe_empty_i, go to ISSUE. Otherwise hold. kill_i and pipe_empty_i asserted together: kill wins.
- ISSUE: csr_valid_o=1 for exactly this one cycle, with the registered fields driven. kill_i is ignored here because the access is committed. At the clock edge, latch the response and go to RESP:
  - wb_valid=1 when !csr_trap_i, the op is CSRRW/RS/RC, and rd≠0; wb_data=csr_rdata_i.
  - redirect_pc = csr_trap_i ? csr_trap_vector_i : pc + NextPcOffset, with modulo-2^Xlen wrap.
  - redirect_valid=1 always.
- RESP: wb_*_o and redirect_*_o are valid for exactly one cycle, then cleared; go to IDLE.
- Exception requests: forwarded unchanged. The CSR file raises the trap and the vector comes from csr_trap_vector_i. MRET traps to mepc through the same path. No writeback on any trap.
- Latency: request accept to csr_valid_o = 2 cycles minimum (IDLE→DRAIN→ISSUE). csr_valid_o to redirect = 1 cycle. Minimum spacing between accepted requests = 4 cycles.
- When csr_valid_o=0, csr_op_o and all other csr_* fields are held but must be ignored.

Optional Feature:
- Macro CSR_ISSUE_STALL_CNT_EN.
- Defined: stall_cnt_o increments each cycle spent in DRAIN with pipe_empty_i=0 and kill_i=0. It saturates at all-ones and is cleared only by reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- csr_pkg holds the state enum csr_issue_state_e.
- csr_op_e and csr_mcause_e are reused from the existing packages.
- Xlen comes from core_pkg.
- One sub-module is natural: sat_counter (parameterized width, inc/clear), instantiated only under CSR_ISSUE_STALL_CNT_EN.

Test Plan:
- CSRRW, addr 0x340, rs1=0xAA, rd=5, pipe_empty_i=1, csr_rdata_i=0x11:
  - csr_valid_o high exactly 2 cycles after accept.
  - Next cycle: wb_valid_o=1, wb_rd_o=5, wb_data_o=0x11, redirect_pc_o=pc+4.
- CSRRS with rd=0: no wb_valid_o; redirect_valid_o=1 with pc+4.
- Exception, cause 2, value 0xDEAD, pc 0x100; csr_trap_i=1, vector 0x8000:
  - No writeback; redirect_pc_o=0x8000.
- pipe_empty_i=0 for 7 cycles, then 1:
  - csr_valid_o asserts exactly 1 cycle after pipe_empty_i rises.
  - With the macro defined, stall_cnt_o=7.
- kill_i asserted in DRAIN: returns to IDLE with no csr_valid_o, wb, or redirect; req_ready_o=1 next cycle.
- rst_i pulsed asynchronously mid-DRAIN and again in RESP: all outputs go to 0 immediately; no csr_valid_o issued afterwards.
